// File: rtl/rf68851_ptmem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf68851_ptmem_slave : page-table RAM responder on the rf68851 MMU memory port
// Rev 1.0
// ----------------------------------------------------------------------------
module rf68851_ptmem_slave #(
   parameter logic [31:0] BASE_ADR    = 32'h0020_0000,
   parameter logic [31:0] ADR_MASK    = 32'hFFFF_0000,
   parameter int unsigned DEPTH_LOG2  = 14,
   parameter int unsigned WAIT_STATES = 1,
   parameter bit          WP_USER     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  fc_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        vpa_o
);

   localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_WAIT = 4'b0010,
      S_RESP = 4'b0100,
      S_HOLD = 4'b1000
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [3:0]              r_cnt, w_cnt_nxt;
   logic                    w_sel, w_bad, w_accept, w_wr, w_resp_st;
   logic [DEPTH_LOG2-1:0]   w_idx;

   logic                    r_we, r_bad;
   logic [3:0]              r_sel;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic [31:0]             r_wdat, r_rdata;
   logic [31:0]             r_mem [0:(2**DEPTH_LOG2)-1];

   assign w_sel = cyc_i & stb_i & ((adr_i & ADR_MASK) == BASE_ADR);
   assign w_bad = (fc_i == 3'd7) | (WP_USER & we_i & ~fc_i[2]);
   assign w_idx = adr_i[DEPTH_LOG2+1:2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_sel) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = c_WAIT_INIT;
               w_accept    = 1'b1;
            end
         end
         S_WAIT: begin
            if (!cyc_i)
               w_state_nxt = S_IDLE;
            else if (r_cnt != 4'd0)
               w_cnt_nxt = r_cnt - 4'd1;
            else
               w_state_nxt = S_RESP;
         end
         S_RESP: begin
            // A reset arriving in this cycle must cancel the write.
            w_wr        = r_we & ~r_bad & ~rst_i;
            w_state_nxt = cyc_i ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!cyc_i || !stb_i)
               w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we   <= 1'b0;
         r_bad  <= 1'b0;
         r_sel  <= 4'd0;
         r_idx  <= '0;
         r_wdat <= 32'd0;
      end else if (w_accept) begin
         r_we   <= we_i;
         r_bad  <= w_bad;
         r_sel  <= sel_i;
         r_idx  <= w_idx;
         r_wdat <= dat_i;
      end
   end

   // Block RAM: read launched at accept, byte-masked write committed in RESP.
   always_ff @(posedge clk_i) begin
      if (w_accept)
         r_rdata <= r_mem[w_idx];
      if (w_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (r_sel[b])
               r_mem[r_idx][8*b +: 8] <= r_wdat[8*b +: 8];
         end
      end
   end

   assign w_resp_st = (r_state == S_RESP) | (r_state == S_HOLD);
   assign ack_o     = w_resp_st & ~r_bad;
   assign err_o     = w_resp_st & r_bad;
   assign dat_o     = (w_resp_st & ~r_we & ~r_bad) ? r_rdata : 32'd0;
   assign vpa_o     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_rf68851_ptmem_slave.sv
`default_nettype none
// Bench for rf68851_ptmem_slave: directed vector table, hand-written abort/reset
// sequences, then random traffic against an associative-array memory model.
module tb_rf68851_ptmem_slave;

   localparam int WS = 1;

   logic        clk_i = 1'b0;
   logic        rst_i, cyc_i, stb_i, we_i;
   logic [2:0]  fc_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i, dat_i, dat_o;
   logic        ack_o, err_o, vpa_o;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   rf68851_ptmem_slave #(
      .BASE_ADR(32'h0020_0000), .ADR_MASK(32'hFFFF_0000), .DEPTH_LOG2(14),
      .WAIT_STATES(WS), .WP_USER(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .fc_i(fc_i), .cyc_i(cyc_i), .stb_i(stb_i),
      .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i),
      .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .vpa_o(vpa_o)
   );

   typedef struct {
      logic [2:0]  fc;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] wd;
      logic        resp;
      logic        ack;
      logic        err;
      logic [31:0] dat;
   } vec_t;

   vec_t        tbl [19];
   logic [31:0] mm [int];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [2:0] fc, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] wd);
      fc_i = fc; we_i = we; sel_i = sel; adr_i = adr; dat_i = wd;
      cyc_i = 1'b1; stb_i = 1'b1;
   endtask

   task automatic release_bus();
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
   endtask

   // Full transaction: latency, response, one held cycle, release to idle.
   task automatic do_txn(input string nm, input logic [2:0] fc, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] wd,
                         input logic exp_resp, input logic exp_ack, input logic exp_err,
                         input logic [31:0] exp_dat);
      int lat = 0;
      drive(fc, we, sel, adr, wd);
      while (lat < 8) begin
         tick();
         lat++;
         if (ack_o || err_o) break;
      end
      chk({nm, " resp"}, {62'd0, ack_o, err_o},
          {62'd0, exp_resp & exp_ack, exp_resp & exp_err});
      if (exp_resp) begin
         chk({nm, " latency"}, 64'(lat), 64'(2 + WS));
         chk({nm, " dat"}, {32'd0, dat_o}, {32'd0, exp_dat});
         tick();
         chk({nm, " hold"}, {30'd0, ack_o, err_o, dat_o}, {30'd0, exp_ack, exp_err, exp_dat});
      end
      release_bus();
      tick();
      chk({nm, " release"}, {29'd0, ack_o, err_o, vpa_o, dat_o}, 64'd0);
   endtask

   // Expectations derived from the window, function-code and byte-lane rules.
   task automatic model_txn(input string nm, input logic [2:0] fc, input logic we,
                            input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] wd);
      logic in_win, bad;
      int   widx;
      logic [31:0] cur;
      in_win = ((adr & 32'hFFFF_0000) == 32'h0020_0000);
      bad    = (fc == 3'd7) || (we && !fc[2]);
      widx   = int'((adr >> 2) & 32'h3FFF);
      cur    = mm.exists(widx) ? mm[widx] : 32'd0;
      do_txn(nm, fc, we, sel, adr, wd, in_win, !bad, bad, (!we && !bad) ? cur : 32'd0);
      if (in_win && we && !bad) begin
         for (int b = 0; b < 4; b++)
            if (sel[b]) cur[8*b +: 8] = wd[8*b +: 8];
         mm[widx] = cur;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] fcs [5];
      logic       any;
      int         lat;
      fcs[0] = 3'd1; fcs[1] = 3'd2; fcs[2] = 3'd5; fcs[3] = 3'd6; fcs[4] = 3'd7;

      //           fc    we    sel    adr            wd            resp  ack   err   dat
      tbl[0]  = '{3'd5, 1'b1, 4'hF, 32'h0020_0040, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{3'd5, 1'b0, 4'hF, 32'h0020_0040, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[2]  = '{3'd6, 1'b1, 4'hF, 32'h0020_0080, 32'h11223344, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{3'd5, 1'b1, 4'h1, 32'h0020_0080, 32'h000000AA, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{3'd5, 1'b0, 4'h0, 32'h0020_0080, 32'h0,        1'b1, 1'b1, 1'b0, 32'h112233AA};
      tbl[5]  = '{3'd1, 1'b1, 4'hF, 32'h0020_0080, 32'h55555555, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[6]  = '{3'd2, 1'b0, 4'hF, 32'h0020_0080, 32'h0,        1'b1, 1'b1, 1'b0, 32'h112233AA};
      tbl[7]  = '{3'd7, 1'b0, 4'hF, 32'h0020_0080, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
      tbl[8]  = '{3'd5, 1'b1, 4'h0, 32'h0020_0080, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[9]  = '{3'd6, 1'b0, 4'hF, 32'h0020_0082, 32'h0,        1'b1, 1'b1, 1'b0, 32'h112233AA};
      tbl[10] = '{3'd5, 1'b1, 4'hA, 32'h0020_0040, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[11] = '{3'd5, 1'b0, 4'hF, 32'h0020_0040, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA1ADC3EF};
      tbl[12] = '{3'd5, 1'b1, 4'hF, 32'h0020_0000, 32'h00204000, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{3'd5, 1'b1, 4'hF, 32'h0020_4040, 32'h12346000, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[14] = '{3'd5, 1'b0, 4'hF, 32'h0020_0000, 32'h0,        1'b1, 1'b1, 1'b0, 32'h00204000};
      tbl[15] = '{3'd5, 1'b0, 4'hF, 32'h0020_4040, 32'h0,        1'b1, 1'b1, 1'b0, 32'h12346000};
      tbl[16] = '{3'd7, 1'b1, 4'hF, 32'h0020_0040, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
      tbl[17] = '{3'd5, 1'b0, 4'hF, 32'h0020_0040, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA1ADC3EF};
      tbl[18] = '{3'd5, 1'b0, 4'hF, 32'h0021_0040, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

      rst_i = 1'b1; fc_i = 3'd0; dat_i = 32'd0; adr_i = 32'd0;
      release_bus();
      repeat (3) tick();
      chk("reset outputs", {29'd0, ack_o, err_o, vpa_o, dat_o}, 64'd0);
      rst_i = 1'b0;
      tick();
      chk("post-reset idle", {29'd0, ack_o, err_o, vpa_o, dat_o}, 64'd0);

      for (int i = 0; i < 19; i++)
         do_txn($sformatf("vec%0d", i), tbl[i].fc, tbl[i].we, tbl[i].sel, tbl[i].adr,
                tbl[i].wd, tbl[i].resp, tbl[i].ack, tbl[i].err, tbl[i].dat);

      // Out-of-window access held for 20 cycles.
      drive(3'd5, 1'b0, 4'hF, 32'h0030_0000, 32'h0);
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("outwin cyc%0d", c), {29'd0, ack_o, err_o, vpa_o, dat_o}, 64'd0);
      end
      release_bus();
      tick();

      // Write aborted by dropping cyc while in WAIT.
      drive(3'd5, 1'b1, 4'hF, 32'h0020_0040, 32'h99999999);
      tick();
      release_bus();
      any = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         any = any | ack_o | err_o;
      end
      chk("abort no response", {63'd0, any}, 64'd0);
      do_txn("abort readback", 3'd5, 1'b0, 4'hF, 32'h0020_0040, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA1ADC3EF);

      // Reset during RESP cancels the pending write.
      drive(3'd5, 1'b1, 4'hF, 32'h0020_0040, 32'h77777777);
      lat = 0;
      while (lat < 8 && !ack_o) begin tick(); lat++; end
      chk("rstresp ack seen", {63'd0, ack_o}, 64'd1);
      rst_i = 1'b1;
      tick();
      chk("rstresp outputs", {30'd0, ack_o, err_o, dat_o}, 64'd0);
      rst_i = 1'b0;
      release_bus();
      tick();
      do_txn("rstresp readback", 3'd5, 1'b0, 4'hF, 32'h0020_0040, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA1ADC3EF);

      // Reset during HOLD on a read.
      drive(3'd6, 1'b0, 4'hF, 32'h0020_0080, 32'h0);
      lat = 0;
      while (lat < 8 && !ack_o) begin tick(); lat++; end
      tick();
      chk("rsthold held", {31'd0, ack_o, dat_o}, {31'd0, 1'b1, 32'h112233AA});
      rst_i = 1'b1;
      tick();
      chk("rsthold outputs", {30'd0, ack_o, err_o, dat_o}, 64'd0);
      rst_i = 1'b0;
      release_bus();
      tick();
      do_txn("rsthold recover", 3'd5, 1'b0, 4'hF, 32'h0020_4040, 32'h0, 1'b1, 1'b1, 1'b0, 32'h12346000);

      // Random traffic over eight preloaded words.
      for (int i = 0; i < 8; i++)
         model_txn($sformatf("preload%0d", i), 3'd5, 1'b1, 4'hF, 32'h0020_0400 + 32'(4 * i), $urandom);
      for (int i = 0; i < 50; i++) begin
         logic [31:0] a;
         a = 32'h0020_0400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a ^ 32'h0010_0000;
         model_txn($sformatf("rand%0d", i), fcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                   4'($urandom), a, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
